// File: rtl/store_size_rmw_pkg.sv
// store_size_pkg: shared definitions for the store-size read-modify-write unit.
//   - SS_* store-size codes (same encoding as the load-size decode).
//   - FSM state enum used by store_size_rmw.
//   - store_misaligned(): alignment rule used when STORE_SIZE_ALIGN_CHK_EN is defined.
package store_size_pkg;

  typedef enum logic [1:0] {
    SS_NOP = 2'b00,
    SS_SW  = 2'b01,
    SS_SH  = 2'b10,
    SS_SB  = 2'b11
  } ss_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } ss_state_e;

  // sw needs a word-aligned address, sh a halfword-aligned one; sb is always legal.
  function automatic logic store_misaligned(input ss_op_e op, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (op)
      SS_SW:   mis = (lo != 2'b00);
      SS_SH:   mis = lo[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_size_rmw_merge.sv
// ss_merge: combinational lane merge for sub-word stores.
//   SScontrol [1:0]  store size code (SS_*)
//   mem_rdata [31:0] word currently in memory
//   B_data    [31:0] register data
//   merged    [31:0] word to write back; sh/sb always replace the low lanes
module ss_merge
  import store_size_pkg::*;
(
  input  logic [1:0]  SScontrol,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] B_data,
  output logic [31:0] merged
);

  always_comb begin
    merged = B_data;
    case (ss_op_e'(SScontrol))
      SS_SH:   merged = {mem_rdata[31:16], B_data[15:0]};
      SS_SB:   merged = {mem_rdata[31:8],  B_data[7:0]};
      default: merged = B_data;
    endcase
  end

endmodule

// File: rtl/store_size_rmw.sv
// store_size_rmw: performs sw/sh/sb against a word-wide data memory.
//   sw writes the register word directly; sh/sb read the target word, merge the
//   low half/byte of the register into it and write it back.
// Parameter:
//   MEM_LAT   cycles from mem_addr valid to mem_rdata valid (1..7)
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               one-cycle request, only sampled in IDLE
//   SScontrol [1:0]     01=sw 10=sh 11=sb 00=no-op
//   addr      [31:0]    byte address; low two bits never reach mem_addr
//   B_data    [31:0]    register data to store
//   mem_rdata [31:0]    memory read data
//   mem_addr  [31:0]    word-aligned address, held from acceptance until IDLE
//   mem_wdata [31:0]    write data
//   mem_wr              write strobe, one cycle per store
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   misalign            only with STORE_SIZE_ALIGN_CHK_EN: pulses with done on a
//                       misaligned sw/sh, which then skips the memory access
module store_size_rmw
  import store_size_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  SScontrol,
  input  logic [31:0] addr,
  input  logic [31:0] B_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done
`ifdef STORE_SIZE_ALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  // READ lasts MEM_LAT cycles: counter loads MEM_LAT-1 and leaves at zero.
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  ss_state_e   state_q;
  logic [2:0]  cnt_q;
  ss_op_e      op_q;
  logic [31:0] b_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] merged;
  ss_op_e      req_op;
  logic        mis_req;

  assign req_op = ss_op_e'(SScontrol);

`ifdef STORE_SIZE_ALIGN_CHK_EN
  logic mis_q;
  assign mis_req  = store_misaligned(req_op, addr[1:0]);
  assign misalign = mis_q;
`else
  assign mis_req = 1'b0;
`endif

  ss_merge u_merge (
    .SScontrol (op_q),
    .mem_rdata (mem_rdata),
    .B_data    (b_q),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= SS_NOP;
      b_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STORE_SIZE_ALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef STORE_SIZE_ALIGN_CHK_EN
      mis_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start && (req_op != SS_NOP)) begin
            addr_q <= addr & ~32'd3;
            b_q    <= B_data;
            op_q   <= req_op;
            busy_q <= 1'b1;
            if (mis_req) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
`ifdef STORE_SIZE_ALIGN_CHK_EN
              mis_q   <= 1'b1;
`endif
            end else if (req_op == SS_SW) begin
              // sw skips the read: write data is ready at acceptance
              state_q <= ST_WRITE;
              wr_q    <= 1'b1;
              wdata_q <= B_data;
            end else begin
              state_q <= ST_READ;
              cnt_q   <= LAT_INIT;
            end
          end
        end
        ST_READ: begin
          if (cnt_q == '0) state_q <= ST_MERGE;
          else             cnt_q   <= cnt_q - 3'd1;
        end
        ST_MERGE: begin
          wdata_q <= merged;
          wr_q    <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = wr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
